// File: rtl/aggr_seq_pkg.sv
// rtl/aggr_seq_pkg.sv - shared FSM state type, default widths and lane helper for the Aggregator sequencer
package aggr_seq_pkg;

  localparam int unsigned IN_PRECISION_DEF  = 3;
  localparam int unsigned OUT_PRECISION_DEF = 6;
  localparam int unsigned DIM_DEF           = 3;
  localparam int unsigned LEN_W_DEF         = 8;
  localparam int unsigned PERF_W            = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACCUM  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Bit offset of a lane inside a packed multi-lane word.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned prec);
    return lane * prec;
  endfunction

endpackage

// File: rtl/aggr_seq_perf.sv
// rtl/aggr_seq_perf.sv - saturating job / stall counter pair for the Aggregator sequencer
module aggr_seq_perf #(
  parameter int unsigned CNT_W = 16
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc_jobs,
  input  logic             i_inc_stalls,
  output logic [CNT_W-1:0] o_jobs,
  output logic [CNT_W-1:0] o_stalls
);

  logic [CNT_W-1:0] r_jobs;
  logic [CNT_W-1:0] r_stalls;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_jobs   <= '0;
      r_stalls <= '0;
    end else begin
      if (i_inc_jobs && (r_jobs != '1))
        r_jobs <= r_jobs + CNT_W'(1);
      if (i_inc_stalls && (r_stalls != '1))
        r_stalls <= r_stalls + CNT_W'(1);
    end
  end

  assign o_jobs   = r_jobs;
  assign o_stalls = r_stalls;

endmodule

// File: rtl/aggr_seq_ctrl.sv
// rtl/aggr_seq_ctrl.sv - job sequencer that clears and feeds the Aggregator, then returns per-lane sums
// AGGR_SEQ_PERF_EN adds saturating perf_jobs / perf_stalls counters.
module aggr_seq_ctrl
  import aggr_seq_pkg::*;
#(
  parameter int unsigned IN_PRECISION  = IN_PRECISION_DEF,
  parameter int unsigned OUT_PRECISION = OUT_PRECISION_DEF,
  parameter int unsigned DIM           = DIM_DEF,
  parameter int unsigned LEN_W         = LEN_W_DEF
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [LEN_W-1:0]             start_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_PRECISION*DIM-1:0]  in_data,
  output logic                         agg_clear,
  output logic [IN_PRECISION*DIM-1:0]  agg_in,
  input  logic [OUT_PRECISION*DIM-1:0] agg_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [OUT_PRECISION*DIM-1:0] res_data,
  output logic                         busy
`ifdef AGGR_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0]            perf_jobs,
  output logic [PERF_W-1:0]            perf_stalls
`endif
);

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [LEN_W-1:0]             r_len;
  logic [LEN_W-1:0]             r_cnt;
  logic [OUT_PRECISION*DIM-1:0] r_res;
  logic                         w_start_hs;
  logic                         w_beat_hs;
  logic                         w_last_beat;

  assign w_start_hs  = start_valid & start_ready;
  assign w_beat_hs   = in_valid & in_ready;
  assign w_last_beat = (r_cnt == r_len - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_hs) begin
        r_len <= start_len;
        r_cnt <= '0;
      end
      if (w_beat_hs)
        r_cnt <= r_cnt + LEN_W'(1);
      // The last beat lands in the accumulator at the edge entering SETTLE.
      if (r_state == S_SETTLE)
        r_res <= agg_out;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    start_ready = 1'b0;
    in_ready    = 1'b0;
    agg_clear   = 1'b0;
    res_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid)
          w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        agg_clear   = 1'b1;
        w_state_nxt = (r_len == '0) ? S_SETTLE : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && w_last_beat)
          w_state_nxt = S_SETTLE;
      end
      S_SETTLE: w_state_nxt = S_DONE;
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Aggregator adds every cycle, so anything but a live beat must be zero.
  assign agg_in   = ((r_state == S_ACCUM) && in_valid) ? in_data : '0;
  assign res_data = r_res;
  assign busy     = (r_state != S_IDLE);

`ifdef AGGR_SEQ_PERF_EN
  logic w_res_hs;
  logic w_stall;

  assign w_res_hs = res_valid & res_ready;
  assign w_stall  = (r_state == S_ACCUM) & ~in_valid;

  aggr_seq_perf #(
    .CNT_W (PERF_W)
  ) u_perf (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_inc_jobs   (w_res_hs),
    .i_inc_stalls (w_stall),
    .o_jobs       (perf_jobs),
    .o_stalls     (perf_stalls)
  );
`endif

endmodule
